// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: player codes, square count,
// move-sequencer FSM states and the square-to-one-hot helper.
package ttt_pkg;

   localparam logic [1:0] PLAYER1 = 2'b01;
   localparam logic [1:0] PLAYER2 = 2'b10;
   localparam int         NUM_SQ  = 9;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_REL,
      LOCK
   } seq_state_t;

   function automatic logic [NUM_SQ-1:0] sq_onehot(input logic [3:0] sq);
      logic [NUM_SQ-1:0] one;
      one = NUM_SQ'(1);
      return one << sq;
   endfunction

endpackage

// File: rtl/ttt_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a stability counter.
// Ports: clk, reset (sync, active-high), btn (raw async input);
//   level (accepted level), press_pulse / release_pulse (1-cycle, on accepted edges).
module ttt_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1         <= 1'b0;
         sync2         <= 1'b0;
         cnt           <= '0;
         level         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         sync1         <= btn;
         sync2         <= sync1;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            // Synced level has disagreed long enough: accept it.
            cnt           <= '0;
            level         <= sync2;
            press_pulse   <= sync2;
            release_pulse <= ~sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ttt_move_sequencer.sv
// Turns the debounced commit button and square select into 1-cycle one-hot
// write enables, alternating players. Ports: clk, reset, sq_sel, commit_btn,
// ill_move, game_over in; p1_en, p2_en, turn, rejected, locked out.
module ttt_move_sequencer
   import ttt_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        sq_sel,
   input  logic              commit_btn,
   input  logic              ill_move,
   input  logic              game_over,
   output logic [NUM_SQ-1:0] p1_en,
   output logic [NUM_SQ-1:0] p2_en,
   output logic [1:0]        turn,
   output logic              rejected,
   output logic              locked
);

   logic btn_level;
   logic btn_press;
   logic btn_release;

   ttt_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_debounce (
      .clk          (clk),
      .reset        (reset),
      .btn          (commit_btn),
      .level        (btn_level),
      .press_pulse  (btn_press),
      .release_pulse(btn_release)
   );

   seq_state_t        state;
   seq_state_t        state_d;
   logic [1:0]        turn_d;
   logic [NUM_SQ-1:0] p1_d;
   logic [NUM_SQ-1:0] p2_d;
   logic              rej_d;
   logic              locked_d;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   // The enable registers are loaded on the press cycle, so they double
   // as the latch of the selected square; later sq_sel changes are ignored.
   always_comb begin
      state_d = state;
      turn_d  = turn;
      p1_d    = '0;
      p2_d    = '0;
      rej_d   = 1'b0;
      unique case (state)
         IDLE: begin
            if (game_over) begin
               state_d = LOCK;
            end else if (btn_press) begin
               if (sq_sel < 4'(NUM_SQ)) begin
                  state_d = ISSUE;
                  if (turn == PLAYER1) p1_d = sq_onehot(sq_sel);
                  else                 p2_d = sq_onehot(sq_sel);
               end else begin
                  state_d = WAIT_REL;
                  rej_d   = 1'b1;
               end
            end
         end
         ISSUE: begin
            // Enable is on the bus now; the detector answers this cycle.
            rej_d = ill_move;
            if (!ill_move) turn_d = (turn == PLAYER1) ? PLAYER2 : PLAYER1;
            state_d = game_over ? LOCK : WAIT_REL;
         end
         WAIT_REL: begin
            if (game_over)                     state_d = LOCK;
            else if (btn_release || !btn_level) state_d = IDLE;
         end
         LOCK: begin
            state_d = LOCK;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      locked_d = (state_d == LOCK);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p1_en    <= '0;
         p2_en    <= '0;
         turn     <= PLAYER1;
         rejected <= 1'b0;
         locked   <= 1'b0;
      end else begin
         p1_en    <= p1_d;
         p2_en    <= p2_d;
         turn     <= turn_d;
         rejected <= rej_d;
         locked   <= locked_d;
      end
   end

endmodule
